// File: rtl/wired_inst_buffer_pkg.sv
// Shared types and constants for the instruction buffer slice.
package wired_inst_buffer_pkg;

    localparam int unsigned INST_BUF_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    localparam int unsigned IBUF_PAYLOAD_W = $bits(ibuf_entry_t);

    // Fetch packet slot-mask encodings; slot 0 is the older instruction.
    localparam logic [1:0] PKT_MASK_NONE = 2'b00;
    localparam logic [1:0] PKT_MASK_S0   = 2'b01;
    localparam logic [1:0] PKT_MASK_S1   = 2'b10;
    localparam logic [1:0] PKT_MASK_BOTH = 2'b11;

endpackage

// File: rtl/wired_inst_buffer_if.sv
// Fetch-packet and decode-slot signals between frontend, buffer and decode.
interface wired_inst_buffer_if
    import wired_inst_buffer_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = IBUF_PAYLOAD_W
);
    logic                      flush_i;
    logic                      pkg_valid_i;
    logic                      pkg_ready_o;
    logic [1:0]                pkg_mask_i;
    logic [1:0][PAYLOAD_W-1:0] pkg_i;
    logic [1:0]                out_valid_o;
    logic [1:0]                out_ready_i;
    logic [1:0][PAYLOAD_W-1:0] out_o;

    // Frontend/decode side.
    modport master (
        output flush_i, pkg_valid_i, pkg_mask_i, pkg_i, out_ready_i,
        input  pkg_ready_o, out_valid_o, out_o
    );

    // Buffer side.
    modport slave (
        input  flush_i, pkg_valid_i, pkg_mask_i, pkg_i, out_ready_i,
        output pkg_ready_o, out_valid_o, out_o
    );
endinterface

// File: rtl/wired_inst_buffer_bank.sv
// One storage bank: single write port, two combinational read ports.
module wired_inst_buffer_bank #(
    parameter int unsigned ENTRIES   = 4,
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [$clog2(ENTRIES)-1:0]      waddr,
    input  logic [PAYLOAD_W-1:0]            wdata,
    input  logic [1:0][$clog2(ENTRIES)-1:0] raddr,
    output logic [1:0][PAYLOAD_W-1:0]       rdata
);
    logic [PAYLOAD_W-1:0] mem_q [ENTRIES];

    // Contents need no reset: validity is tracked by the pointers in the top.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports are plain muxes of the registered array.
    always_comb begin
        rdata[0] = mem_q[raddr[0]];
        rdata[1] = mem_q[raddr[1]];
    end
endmodule

// File: rtl/wired_inst_buffer.sv
// 2-wide decoupling FIFO from fetch packets to decode, compacting masked slots.
module wired_inst_buffer
    import wired_inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = INST_BUF_DEPTH,
    parameter int unsigned PAYLOAD_W = IBUF_PAYLOAD_W
) (
    input logic                clk,
    input logic                rst,
    wired_inst_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = AW - 1;
    localparam logic [AW:0] CNT_READY_MAX = (AW + 1)'(DEPTH - 2);
    localparam logic [AW:0] CNT_ONE       = (AW + 1)'(1);
    localparam logic [AW:0] CNT_TWO       = (AW + 1)'(2);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_en_q;

    logic          pkg_ready;
    logic [1:0]    out_valid;
    logic          enq;
    logic          deq0, deq1;
    logic [1:0]    enq_n, deq_n;
    logic          wr_en0, wr_en1;
    logic [PAYLOAD_W-1:0] wr_data0;

    logic [BW-1:0] tail_hi, tail_up, head_hi, head_up;

    logic                      even_we, odd_we;
    logic [BW-1:0]             even_waddr;
    logic [PAYLOAD_W-1:0]      even_wdata, odd_wdata;
    logic [1:0][BW-1:0]        even_raddr, odd_raddr;
    logic [1:0][PAYLOAD_W-1:0] even_rdata, odd_rdata;

    // Ready depends only on registered state (plus flush) to break the long path.
    always_comb begin
        pkg_ready    = ready_en_q & (count_q <= CNT_READY_MAX) & ~bus.flush_i;
        out_valid[0] = count_q >= CNT_ONE;
        out_valid[1] = count_q >= CNT_TWO;
        enq          = bus.pkg_valid_i & pkg_ready;
        deq0         = out_valid[0] & bus.out_ready_i[0];
        deq1         = deq0 & out_valid[1] & bus.out_ready_i[1];
        deq_n        = {deq1, deq0 & ~deq1};
    end

    // Compact the packet: the first valid slot always lands at tail.
    always_comb begin
        enq_n    = 2'd0;
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        wr_data0 = bus.pkg_i[0];
        if (enq) begin
            unique case (bus.pkg_mask_i)
                PKT_MASK_BOTH: begin
                    enq_n  = 2'd2;
                    wr_en0 = 1'b1;
                    wr_en1 = 1'b1;
                end
                PKT_MASK_S0: begin
                    enq_n  = 2'd1;
                    wr_en0 = 1'b1;
                end
                PKT_MASK_S1: begin
                    enq_n    = 2'd1;
                    wr_en0   = 1'b1;
                    wr_data0 = bus.pkg_i[1];
                end
                PKT_MASK_NONE: begin
                    enq_n = 2'd0;
                end
                default: begin
                    enq_n = 2'd0;
                end
            endcase
        end
    end

    // Pointer and occupancy update; flush wins over any same-cycle traffic.
    always_comb begin
        head_d  = head_q + AW'(deq_n);
        tail_d  = tail_q + AW'(enq_n);
        count_d = count_q + (AW + 1)'(enq_n) - (AW + 1)'(deq_n);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer state; ready_en_q holds pkg_ready low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
        end
    end

    // Bank steering: address LSB selects the bank, upper bits index within it.
    always_comb begin
        tail_hi = tail_q[AW-1:1];
        tail_up = tail_hi + BW'(1);
        head_hi = head_q[AW-1:1];
        head_up = head_hi + BW'(1);

        // Odd tail sends slot 0 to the odd bank and slot 1 to the next even row.
        even_we    = tail_q[0] ? wr_en1 : wr_en0;
        even_waddr = tail_q[0] ? tail_up : tail_hi;
        even_wdata = tail_q[0] ? bus.pkg_i[1] : wr_data0;
        odd_we     = tail_q[0] ? wr_en0 : wr_en1;
        odd_wdata  = tail_q[0] ? wr_data0 : bus.pkg_i[1];

        // Port 0 serves decode slot 0, port 1 serves decode slot 1.
        even_raddr[0] = head_hi;
        even_raddr[1] = head_up;
        odd_raddr[0]  = head_hi;
        odd_raddr[1]  = head_hi;
    end

    wired_inst_buffer_bank #(
        .ENTRIES  (DEPTH / 2),
        .PAYLOAD_W(PAYLOAD_W)
    ) u_bank_even (
        .clk  (clk),
        .we   (even_we),
        .waddr(even_waddr),
        .wdata(even_wdata),
        .raddr(even_raddr),
        .rdata(even_rdata)
    );

    wired_inst_buffer_bank #(
        .ENTRIES  (DEPTH / 2),
        .PAYLOAD_W(PAYLOAD_W)
    ) u_bank_odd (
        .clk  (clk),
        .we   (odd_we),
        .waddr(tail_hi),
        .wdata(odd_wdata),
        .raddr(odd_raddr),
        .rdata(odd_rdata)
    );

    // Drive decode: oldest entry on slot 0, next oldest on slot 1.
    always_comb begin
        bus.pkg_ready_o = pkg_ready;
        bus.out_valid_o = out_valid;
        bus.out_o[0]    = head_q[0] ? odd_rdata[0] : even_rdata[0];
        bus.out_o[1]    = head_q[0] ? even_rdata[1] : odd_rdata[1];
    end
endmodule

// File: tb/tb_wired_inst_buffer.sv
// Directed self-checking bench for wired_inst_buffer (DEPTH=8).
module tb_wired_inst_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wired_inst_buffer_if #(.PAYLOAD_W(64)) bus ();

    wired_inst_buffer #(
        .DEPTH    (8),
        .PAYLOAD_W(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {pc, ~pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc0,
                         input logic [31:0] pc1, input logic [1:0] rdy);
        bus.pkg_valid_i = v;
        bus.pkg_mask_i  = m;
        bus.pkg_i[0]    = mk(pc0);
        bus.pkg_i[1]    = mk(pc1);
        bus.out_ready_i = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush_i = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        #3;
        checks++;
        if (bus.out_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 00", bus.out_valid_o);
        end
        checks++;
        if (bus.pkg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", bus.pkg_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pkg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", bus.pkg_ready_o);
        end
        tick();
        checks++;
        if (bus.pkg_ready_o !== 1'b1 || dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL ready_after_edge: got %b/%0d expected 1/0",
                     bus.pkg_ready_o, dut.count_q);
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 32'(i * 8), 32'(i * 8 + 4), 2'b00);
            checks++;
            if (bus.pkg_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b expected 1", i, bus.pkg_ready_o);
            end
            tick();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (dut.count_q !== 4'd8 || bus.pkg_ready_o !== 1'b0 || bus.out_valid_o !== 2'b11) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b val=%b expected 8/0/11",
                     dut.count_q, bus.pkg_ready_o, bus.out_valid_o);
        end
        // Drain two per cycle and check program order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
            checks++;
            if (bus.out_o[0] !== mk(32'(i * 8)) || bus.out_o[1] !== mk(32'(i * 8 + 4))) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got %h %h expected pcs %h %h", i,
                         bus.out_o[0], bus.out_o[1], i * 8, i * 8 + 4);
            end
            tick();
            exp_cnt = 4'(6 - 2 * i);
            checks++;
            if (dut.count_q !== exp_cnt) begin
                errors++;
                $display("FAIL fill_cnt[%0d]: got %0d expected %0d", i, dut.count_q, exp_cnt);
            end
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (bus.out_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL fill_empty: got %b expected 00", bus.out_valid_o);
        end
    endtask

    task automatic test_masks();
        // Mask 10: only slot 1 (pc 0x4) is kept.
        drive(1'b1, 2'b10, 32'hDEAD_0000, 32'h4, 2'b11);
        tick();
        drive(1'b1, 2'b01, 32'h8, 32'hDEAD_0004, 2'b11);
        checks++;
        if (bus.out_valid_o !== 2'b01 || bus.out_o[0] !== mk(32'h4)) begin
            errors++;
            $display("FAIL mask10: got val=%b %h expected 01 pc 4", bus.out_valid_o,
                     bus.out_o[0]);
        end
        tick();
        drive(1'b1, 2'b00, 32'hDEAD_0008, 32'hDEAD_000C, 2'b11);
        checks++;
        if (bus.out_valid_o !== 2'b01 || bus.out_o[0] !== mk(32'h8) || bus.pkg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mask01: got val=%b %h rdy=%b expected 01 pc 8 rdy 1",
                     bus.out_valid_o, bus.out_o[0], bus.pkg_ready_o);
        end
        tick();
        drive(1'b1, 2'b11, 32'hC, 32'h10, 2'b11);
        checks++;
        if (bus.out_valid_o !== 2'b00 || dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL mask00: got val=%b cnt=%0d expected 00/0", bus.out_valid_o,
                     dut.count_q);
        end
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        checks++;
        if (bus.out_valid_o !== 2'b11 || bus.out_o[0] !== mk(32'hC) ||
            bus.out_o[1] !== mk(32'h10)) begin
            errors++;
            $display("FAIL mask11: got val=%b %h %h expected 11 pcs C 10",
                     bus.out_valid_o, bus.out_o[0], bus.out_o[1]);
        end
        tick();
        checks++;
        if (dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL mask_drain: got %0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_full_boundary();
        drive(1'b1, 2'b11, 32'h100, 32'h104, 2'b00);
        tick();
        drive(1'b1, 2'b11, 32'h108, 32'h10C, 2'b00);
        tick();
        drive(1'b1, 2'b11, 32'h110, 32'h114, 2'b00);
        tick();
        drive(1'b1, 2'b01, 32'h118, 32'hDEAD_0000, 2'b00);
        tick();
        drive(1'b1, 2'b11, 32'hBAD0, 32'hBAD4, 2'b11);
        checks++;
        if (dut.count_q !== 4'd7 || bus.pkg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full7_ready: got cnt=%0d rdy=%b expected 7/0", dut.count_q,
                     bus.pkg_ready_o);
        end
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (dut.count_q !== 4'd5 || bus.pkg_ready_o !== 1'b1 || bus.out_o[0] !== mk(32'h108)) begin
            errors++;
            $display("FAIL full7_after: got cnt=%0d rdy=%b %h expected 5/1 pc 108",
                     dut.count_q, bus.pkg_ready_o, bus.out_o[0]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
            tick();
        end
        checks++;
        if (dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL full7_drain: got %0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_partial_ready();
        drive(1'b1, 2'b11, 32'h200, 32'h204, 2'b00);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
        tick();
        checks++;
        if (dut.count_q !== 4'd2 || bus.out_o[0] !== mk(32'h200)) begin
            errors++;
            $display("FAIL ready10: got cnt=%0d %h expected 2 pc 200", dut.count_q,
                     bus.out_o[0]);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
        tick();
        checks++;
        if (dut.count_q !== 4'd1 || bus.out_o[0] !== mk(32'h204) || bus.out_valid_o !== 2'b01) begin
            errors++;
            $display("FAIL ready01: got cnt=%0d val=%b %h expected 1/01 pc 204",
                     dut.count_q, bus.out_valid_o, bus.out_o[0]);
        end
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL ready01_last: got %0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] pc_next;
        logic [1:0]  m, rdy;
        logic [1:0]  exp_val;
        int          mcount, sent, got, bad;
        logic        v, d0, d1;
        pc_next = 32'h1000;
        mcount  = 0;
        sent    = 0;
        got     = 0;
        bad     = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            v   = sent < 20;
            m   = (20 - sent >= 2) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(1, 2));
            if (!v) m = 2'b00;
            rdy = 2'($urandom_range(0, 3));
            drive(v, m, (m == 2'b10) ? 32'hDEAD_0000 : pc_next,
                  (m == 2'b11) ? pc_next + 32'd4 : ((m == 2'b10) ? pc_next : 32'hDEAD_0004),
                  rdy);
            exp_val = {mcount >= 2, mcount >= 1};
            checks++;
            if (bus.out_valid_o !== exp_val || bus.pkg_ready_o !== (mcount <= 6)) begin
                errors++;
                $display("FAIL wrap_ctl[%0d]: got val=%b rdy=%b expected %b/%b", cyc,
                         bus.out_valid_o, bus.pkg_ready_o, exp_val, mcount <= 6);
            end
            if (mcount >= 1) begin
                checks++;
                if (bus.out_o[0] !== mk(q[0])) begin
                    errors++;
                    $display("FAIL wrap_out0[%0d]: got %h expected pc %h", cyc,
                             bus.out_o[0], q[0]);
                end
            end
            if (mcount >= 2) begin
                checks++;
                if (bus.out_o[1] !== mk(q[1])) begin
                    errors++;
                    $display("FAIL wrap_out1[%0d]: got %h expected pc %h", cyc,
                             bus.out_o[1], q[1]);
                end
            end
            d0 = (mcount >= 1) && rdy[0];
            d1 = d0 && (mcount >= 2) && rdy[1];
            if (d0) begin void'(q.pop_front()); got++; mcount--; end
            if (d1) begin void'(q.pop_front()); got++; mcount--; end
            if (v && (mcount + int'(d0) + int'(d1)) <= 6) begin
                if (m == 2'b11) begin
                    q.push_back(pc_next);
                    q.push_back(pc_next + 32'd4);
                    pc_next = pc_next + 32'd8;
                    sent += 2;
                    mcount += 2;
                end else begin
                    q.push_back(pc_next);
                    pc_next = pc_next + 32'd4;
                    sent += 1;
                    mcount += 1;
                end
            end
            tick();
            checks++;
            if (dut.count_q !== 4'(mcount) || dut.count_q > 4'd8) begin
                errors++;
                $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", cyc, dut.count_q, mcount);
            end
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL wrap_done: got %0d instructions expected 20", got);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 2'b11, 32'h300, 32'h304, 2'b00);
        tick();
        drive(1'b1, 2'b11, 32'h308, 32'h30C, 2'b00);
        tick();
        drive(1'b1, 2'b01, 32'h310, 32'hDEAD_0000, 2'b00);
        tick();
        bus.flush_i = 1'b1;
        drive(1'b1, 2'b11, 32'hBAD0, 32'hBAD4, 2'b11);
        checks++;
        if (dut.count_q !== 4'd5 || bus.pkg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got cnt=%0d rdy=%b expected 5/0", dut.count_q,
                     bus.pkg_ready_o);
        end
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (bus.out_valid_o !== 2'b00 || dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL flush_clear: got val=%b cnt=%0d expected 00/0", bus.out_valid_o,
                     dut.count_q);
        end
        drive(1'b1, 2'b11, 32'h400, 32'h404, 2'b00);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (dut.count_q !== 4'd2 || bus.out_o[0] !== mk(32'h400) || bus.out_o[1] !== mk(32'h404)) begin
            errors++;
            $display("FAIL flush_after: got cnt=%0d %h %h expected 2 pcs 400 404",
                     dut.count_q, bus.out_o[0], bus.out_o[1]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'b01, 32'h500, 32'h0, 2'b00);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (dut.count_q !== 4'd3) begin
            errors++;
            $display("FAIL rst_mid_pre: got %0d expected 3", dut.count_q);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid_o !== 2'b00 || bus.pkg_ready_o !== 1'b0 || dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got val=%b rdy=%b cnt=%0d expected 00/0/0",
                     bus.out_valid_o, bus.pkg_ready_o, dut.count_q);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (bus.pkg_ready_o !== 1'b1 || bus.out_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_release: got rdy=%b val=%b expected 1/00",
                     bus.pkg_ready_o, bus.out_valid_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_masks();
        test_full_boundary();
        test_partial_ready();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
